// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch unit with a DEPTH-entry FIFO.
//   Issues sequential word-aligned fetches to instruction memory and buffers
//   each returned word with its address until decode consumes it.
//   A redirect flushes the FIFO and restarts fetch at the new address.
//
// Ports:
//   clk, reset             - clock; synchronous active-high reset
//   imem_req, imem_addr    - fetch request / word-aligned address
//   imem_ack, imem_rdata   - same-cycle accept and instruction data
//   redirect, redirect_pc  - flush and restart fetch at redirect_pc & ~3
//   inst_valid, inst_ready - FIFO head handshake towards decode
//   instruction, inst_pc   - FIFO head word and the address it came from
//   fetch_stalls           - only with FETCH_UNIT_PERF_CNT_EN defined:
//                            saturating count of cycles with
//                            inst_ready & !inst_valid
//
// Build option: FETCH_UNIT_PERF_CNT_EN adds the fetch_stalls counter/port.

module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
`ifdef FETCH_UNIT_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stalls
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {BOOT, RUN, FULL, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [31:0]     mem_inst [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;

  assign imem_req    = (state == RUN);
  assign imem_addr   = fetch_pc;
  assign inst_valid  = (count != '0) && (state != FLUSH);
  assign instruction = mem_inst[rd_ptr];
  assign inst_pc     = mem_pc[rd_ptr];

  // Redirect wins over both FIFO ports: acked data in that cycle is dropped.
  assign push = imem_req && imem_ack && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FLUSH;
    end else begin
      unique case (state)
        BOOT:  state_nxt = RUN;
        RUN:   if (push && !pop && count == LAST_CNT) state_nxt = FULL;
        FULL:  if (pop) state_nxt = RUN;
        FLUSH: state_nxt = RUN;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          mem_inst[wr_ptr] <= imem_rdata;
          mem_pc[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + AW'(1);
          fetch_pc         <= fetch_pc + 32'd4;  // wraps FFFFFFFC -> 0
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        unique case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_UNIT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_stalls <= '0;
    end else if (inst_ready && !inst_valid && fetch_stalls != '1) begin
      fetch_stalls <= fetch_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
//   A predictor keeps an abstract model (fetch address, FIFO occupancy,
//   one-cycle boot/flush gaps) and pushes every expected handshake word into
//   a scoreboard queue; a separate monitor pops and compares whenever decode
//   consumes the FIFO head.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
`ifdef FETCH_UNIT_PERF_CNT_EN
  logic [31:0] fetch_stalls;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .instruction(instruction),
    .inst_pc(inst_pc)
`ifdef FETCH_UNIT_PERF_CNT_EN
    ,
    .fetch_stalls(fetch_stalls)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: abstract fetch model evaluated once per cycle.
  int unsigned occ;
  logic [31:0] mpc;
  bit          boot, flush;
  logic [31:0] mstalls;

  always @(negedge clk) begin
    bit er, ev, hs, cons;
    if (reset) begin
      occ = 0; mpc = RPC; boot = 1; flush = 0; mstalls = '0;
      sb.delete();
    end else begin
      er = !boot && !flush && (occ < DEPTH);
      ev = (occ > 0);
      check("imem_req", {31'b0, imem_req}, {31'b0, er});
      check("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
      if (er) check("imem_addr", imem_addr, mpc);
      if (boot) begin
        check("reset_instruction", instruction, 32'h0);
        check("reset_inst_pc", inst_pc, 32'h0);
      end
`ifdef FETCH_UNIT_PERF_CNT_EN
      check("fetch_stalls", fetch_stalls, mstalls);
      if (inst_ready && !ev && mstalls != 32'hFFFF_FFFF) mstalls = mstalls + 1;
`endif
      if (redirect) begin
        occ = 0;
        sb.delete();
        mpc = redirect_pc & 32'hFFFF_FFFC;
        flush = 1; boot = 0;
      end else begin
        cons = ev && inst_ready;
        hs   = er && imem_ack;
        if (hs) begin
          sb.push_back('{pc: mpc, inst: imem_rdata});
          mpc = mpc + 32'd4;
        end
        occ = occ + (hs ? 1 : 0) - (cons ? 1 : 0);
        flush = 0; boot = 0;
      end
    end
  end

  // Monitor: compares each consumed FIFO head against the scoreboard.
  always @(negedge clk) begin
    ent_t e;
    if (!reset && !redirect && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got pop of pc %h expected no valid head", inst_pc);
      end else begin
        e = sb.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("instruction", instruction, e.inst);
      end
    end
  end

  task automatic step(input bit a, input bit r, input bit rd = 1'b0, input logic [31:0] rp = '0);
    imem_ack    = a;
    inst_ready  = r;
    redirect    = rd;
    redirect_pc = rp;
    imem_rdata  = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step(1, 1, 1, 32'h55);
    reset = 1'b0;
    // stall counting after reset with memory not acking
    repeat (10) step(0, 1);
    // streaming
    repeat (20) step(1, 1);
    // fill to FULL, single pop, refill
    repeat (10) step(1, 0);
    step(1, 1);
    repeat (3) step(1, 0);
    repeat (8) step(0, 1);
    // three buffered entries then redirect to an unaligned address
    repeat (3) step(1, 0);
    step(1, 0, 1, 32'h103);
    repeat (6) step(1, 1);
    // memory holds off acks for 5 cycles
    repeat (5) step(0, 1);
    repeat (4) step(1, 1);
    // back-to-back redirects (latest wins) into the address wrap
    step(1, 1, 1, 32'h200);
    step(1, 1, 1, 32'hFFFF_FFF9);
    repeat (6) step(1, 1);
    // randomized traffic with occasional reset
    repeat (600) begin
      reset = ($urandom % 150 == 0);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
    end
    reset = 1'b0;
    repeat (12) step(0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
